// File: rtl/lsu_pkg.sv
// Shared size codes, FSM state encoding and load-context record for the BRAM load/store unit.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RDWAIT = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // Load attributes captured at accept, consumed when the BRAM data returns.
    typedef struct packed {
        logic [1:0] offset;
        logic [1:0] size;
        logic       is_unsigned;
    } ld_ctx_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] mask;
        mask = 4'b0000;
        case (size)
            SIZE_B:  mask = 4'b0001 << offset;
            SIZE_H:  mask = offset[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/bram_lsu_ctrl_if.sv
// Core request/response channel plus the single-port BRAM port of bram_lsu_ctrl.
interface bram_lsu_ctrl_if #(
    parameter int ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_ce;
    logic              mem_oce;
    logic              mem_wre;
    logic [ADDR_W-1:0] mem_ad;
    logic [31:0]       mem_din;
    logic [3:0]        mem_byte_en;
    logic [31:0]       mem_dout;

    // slave is the LSU; master is the core together with the BRAM.
    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  rsp_ready, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_ce, mem_oce, mem_wre, mem_ad, mem_din, mem_byte_en
    );

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output rsp_ready, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_ce, mem_oce, mem_wre, mem_ad, mem_din, mem_byte_en
    );

endinterface

// File: rtl/lsu_lane_steer.sv
// Combinational lane logic: access legality, store steering/byte enables and load extract/extend.
module lsu_lane_steer
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic [31:0] i_addr,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_wdata,
    output logic        o_err,
    output logic [31:0] o_din,
    output logic [3:0]  o_byte_en,
    input  ld_ctx_t     i_rd_ctx,
    input  logic [31:0] i_rd_raw,
    output logic [31:0] o_rd_data
);

    logic        w_misaligned;
    logic        w_out_of_range;
    logic [7:0]  w_rd_byte;
    logic [15:0] w_rd_half;

    always_comb begin
        w_misaligned = 1'b0;
        case (i_size)
            SIZE_B:  w_misaligned = 1'b0;
            SIZE_H:  w_misaligned = i_addr[0];
            SIZE_W:  w_misaligned = |i_addr[1:0];
            default: w_misaligned = 1'b1;
        endcase
    end

    // Any set bit above the BRAM byte-address space is out of range.
    assign w_out_of_range = |(i_addr >> (ADDR_W + 2));
    assign o_err          = w_misaligned | w_out_of_range;

    always_comb begin
        o_din = i_wdata;
        case (i_size)
            SIZE_B:  o_din = {4{i_wdata[7:0]}};
            SIZE_H:  o_din = {2{i_wdata[15:0]}};
            default: o_din = i_wdata;
        endcase
    end

    assign o_byte_en = lane_mask(i_size, i_addr[1:0]);

    always_comb begin
        w_rd_byte = i_rd_raw[7:0];
        case (i_rd_ctx.offset)
            2'd0: w_rd_byte = i_rd_raw[7:0];
            2'd1: w_rd_byte = i_rd_raw[15:8];
            2'd2: w_rd_byte = i_rd_raw[23:16];
            2'd3: w_rd_byte = i_rd_raw[31:24];
            default: w_rd_byte = i_rd_raw[7:0];
        endcase
        w_rd_half = i_rd_ctx.offset[1] ? i_rd_raw[31:16] : i_rd_raw[15:0];
    end

    always_comb begin
        o_rd_data = i_rd_raw;
        case (i_rd_ctx.size)
            SIZE_B:  o_rd_data = {{24{~i_rd_ctx.is_unsigned & w_rd_byte[7]}}, w_rd_byte};
            SIZE_H:  o_rd_data = {{16{~i_rd_ctx.is_unsigned & w_rd_half[15]}}, w_rd_half};
            default: o_rd_data = i_rd_raw;
        endcase
    end

endmodule

// File: rtl/bram_lsu_ctrl.sv
// Load/store front end for a 32-bit single-port BRAM: one request in flight, one response per request.
//
// state  | meaning
// IDLE   | ready for a request; legal accesses drive the BRAM in the accept cycle
// RDWAIT | BRAM read data is on mem_dout; extract and capture it
// RESP   | response held on rsp_* until rsp_ready
module bram_lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    bram_lsu_ctrl_if.slave bus
);

    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("bram_lsu_ctrl: DATA_W must be 32");
        end
    endgenerate

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;
    ld_ctx_t           r_ld_ctx;

    logic              w_accept;
    logic              w_err;
    logic [31:0]       w_din;
    logic [3:0]        w_byte_en;
    logic [31:0]       w_rd_data;

    lsu_lane_steer #(
        .ADDR_W (ADDR_W)
    ) u_lane_steer (
        .i_addr    (bus.req_addr),
        .i_size    (bus.req_size),
        .i_wdata   (bus.req_wdata),
        .o_err     (w_err),
        .o_din     (w_din),
        .o_byte_en (w_byte_en),
        .i_rd_ctx  (r_ld_ctx),
        .i_rd_raw  (bus.mem_dout),
        .o_rd_data (w_rd_data)
    );

    assign bus.req_ready = (r_state == IDLE) & ~reset;
    assign w_accept      = bus.req_valid & bus.req_ready;

    // Erroneous requests never touch the memory.
    assign bus.mem_ce      = w_accept & ~w_err & ~reset;
    assign bus.mem_wre     = bus.mem_ce & bus.req_we;
    assign bus.mem_oce     = 1'b1;
    assign bus.mem_ad      = bus.req_addr[ADDR_W+1:2];
    assign bus.mem_din     = w_din;
    assign bus.mem_byte_en = w_byte_en;

    assign bus.rsp_valid = (r_state == RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_ld_ctx <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_rdata  <= '0;
                        r_err    <= w_err;
                        r_ld_ctx <= '{offset:      bus.req_addr[1:0],
                                      size:        bus.req_size,
                                      is_unsigned: bus.req_unsigned};
                        r_state  <= (w_err | bus.req_we) ? RESP : RDWAIT;
                    end
                end
                RDWAIT: begin
                    r_rdata <= w_rd_data;
                    r_state <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_lsu_ctrl.sv
// Self-checking bench for bram_lsu_ctrl: directed scenarios then random traffic against a byte-array model.
module tb_bram_lsu_ctrl;
    import lsu_pkg::*;

    localparam int ADDR_W = 9;
    localparam int WORDS  = 1 << ADDR_W;
    localparam int NBYTES = 1 << (ADDR_W + 2);

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic tb_clear = 1'b1;

    int checks   = 0;
    int failures = 0;

    logic [31:0] last_rdata;
    logic [31:0] bram    [0:WORDS-1];
    logic [7:0]  ref_mem [0:NBYTES-1];

    bram_lsu_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    bram_lsu_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // BRAM: byte-enabled writes, registered reads with one cycle latency.
    always @(posedge clk) begin
        if (tb_clear) begin
            for (int w = 0; w < WORDS; w++) bram[w] <= '0;
        end else if (bus.mem_ce) begin
            if (bus.mem_wre) begin
                for (int k = 0; k < 4; k++)
                    if (bus.mem_byte_en[k]) bram[bus.mem_ad][8*k +: 8] <= bus.mem_din[8*k +: 8];
            end else begin
                bus.mem_dout <= bram[bus.mem_ad];
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size, input logic uns);
        int n;
        logic [31:0] v;
        n = 1 << size;
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input bit hold);
        int          n;
        bit          e_err;
        int          e_lat;
        int          lat;
        logic [31:0] e_rdata;
        logic [31:0] e_din;
        logic [3:0]  e_be;

        n       = 1 << size;
        e_err   = (size == 2'd3) || ((addr % n) != 0) || (addr >= NBYTES);
        e_lat   = (e_err || we) ? 1 : 2;
        e_rdata = (e_err || we) ? 32'h0 : ref_load(addr, size, uns);
        e_be    = 4'(((1 << n) - 1) << addr[1:0]);
        for (int k = 0; k < 4; k++) e_din[8*k +: 8] = wdata[8*(k % n) +: 8];

        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_addr     = addr;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        bus.rsp_ready    = !hold;
        #1;
        chk("req_ready", bus.req_ready, 1'b1);
        chk("accept_mem_ce", bus.mem_ce, !e_err);
        chk("accept_mem_wre", bus.mem_wre, !e_err && we);
        if (!e_err) chk("mem_ad", bus.mem_ad, addr >> 2);
        if (!e_err && we) begin
            chk("mem_byte_en", bus.mem_byte_en, e_be);
            chk("mem_din", bus.mem_din, e_din);
        end
        @(posedge clk);
        if (!e_err && we)
            for (int i = 0; i < n; i++) ref_mem[addr + i] = wdata[8*i +: 8];

        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        lat = 1;
        while (!bus.rsp_valid && lat < 8) begin
            chk("wait_mem_ce", bus.mem_ce, 1'b0);
            @(negedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, e_lat);
        chk("rsp_rdata", bus.rsp_rdata, e_rdata);
        chk("rsp_err", bus.rsp_err, e_err);
        last_rdata = bus.rsp_rdata;

        if (hold) begin
            repeat (5) begin
                @(negedge clk);
                #1;
                chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
                chk("hold_rsp_rdata", bus.rsp_rdata, e_rdata);
                chk("hold_req_ready", bus.req_ready, 1'b0);
                chk("hold_mem_ce", bus.mem_ce, 1'b0);
            end
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk);
    endtask

    initial begin
        logic        r_we;
        logic [1:0]  r_size;
        logic        r_uns;
        logic [31:0] r_addr;

        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_addr     = '0;
        bus.req_size     = SIZE_W;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = '0;
        bus.rsp_ready    = 1'b1;
        for (int b = 0; b < NBYTES; b++) ref_mem[b] = 8'h00;

        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b1;
        #1;
        chk("rst_req_ready", bus.req_ready, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rsp_err", bus.rsp_err, 1'b0);
        chk("rst_mem_ce", bus.mem_ce, 1'b0);
        chk("rst_mem_wre", bus.mem_wre, 1'b0);
        chk("mem_oce", bus.mem_oce, 1'b1);
        bus.req_valid = 1'b0;
        reset    = 1'b0;
        tb_clear = 1'b0;
        #1;
        chk("post_rst_req_ready", bus.req_ready, 1'b1);

        do_req(1'b1, 32'h10, SIZE_W, 1'b0, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, 1'b0);
        chk("ld_word_const", last_rdata, 32'hDEAD_BEEF);

        do_req(1'b1, 32'h13, SIZE_B, 1'b0, 32'h0000_0080, 1'b0);
        do_req(1'b0, 32'h13, SIZE_B, 1'b0, 32'h0, 1'b0);
        chk("ld_sbyte_const", last_rdata, 32'hFFFF_FF80);
        do_req(1'b0, 32'h13, SIZE_B, 1'b1, 32'h0, 1'b0);
        chk("ld_ubyte_const", last_rdata, 32'h0000_0080);

        do_req(1'b1, 32'h10, SIZE_W, 1'b0, 32'h8001_1234, 1'b0);
        do_req(1'b0, 32'h12, SIZE_H, 1'b0, 32'h0, 1'b0);
        chk("ld_shalf_const", last_rdata, 32'hFFFF_8001);
        do_req(1'b0, 32'h12, SIZE_H, 1'b1, 32'h0, 1'b0);
        chk("ld_uhalf_const", last_rdata, 32'h0000_8001);

        do_req(1'b0, 32'h06, SIZE_W, 1'b0, 32'h0, 1'b0);
        do_req(1'b0, 32'h01, SIZE_H, 1'b0, 32'h0, 1'b0);
        do_req(1'b0, 32'h20, 2'd3, 1'b0, 32'h0, 1'b0);
        do_req(1'b0, 32'h800, SIZE_W, 1'b0, 32'h0, 1'b0);
        do_req(1'b1, 32'h800, SIZE_W, 1'b0, 32'h1111_2222, 1'b0);

        do_req(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, 1'b1);

        // Reset while the load waits for BRAM data.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h10;
        bus.req_size  = SIZE_W;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        chk("rdwait_rsp_valid", bus.rsp_valid, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("midrst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("midrst_req_ready", bus.req_ready, 1'b0);
        reset = 1'b0;
        #1;
        chk("after_rst_req_ready", bus.req_ready, 1'b1);
        @(negedge clk);
        #1;
        chk("after_rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("after_rst_req_ready2", bus.req_ready, 1'b1);
        do_req(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, 1'b0);
        chk("after_rst_load", last_rdata, 32'h8001_1234);

        for (int t = 0; t < 120; t++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r_uns  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 15))
                0:       r_addr = 32'h800 + 32'($urandom_range(0, 255));
                1:       r_addr = 32'h8000_0000 | 32'($urandom_range(0, 63));
                default: r_addr = 32'($urandom_range(0, 63));
            endcase
            do_req(r_we, r_addr, r_size, r_uns, $urandom, ($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
